// File: rtl/collision_pkg.sv
// -----------------------------------------------------------------------------
// collision_pkg
// Shared types for the collision tracker:
//   trackStateT  - scan FSM states
//   evtT         - one collision event {pair, frame} as stored in the event FIFO
//   pairIdxWidth - width of a flattened pair index i*NUM_OBJ+j
// -----------------------------------------------------------------------------
package collision_pkg;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        SCAN     = 1'b1
    } trackStateT;

    // Pair field is sized for the largest supported object count (16*16 pairs).
    localparam int MAX_PAIR_W = 8;

    typedef struct packed {
        logic [MAX_PAIR_W-1:0] pair;
        logic [7:0]            frame;
    } evtT;

    function automatic int pairIdxWidth(input int numObj);
        return $clog2(numObj * numObj);
    endfunction

endpackage

// File: rtl/collision_tracker_evt_fifo.sv
// -----------------------------------------------------------------------------
// evt_fifo
// Show-ahead event FIFO with a registered head. The head entry and its valid
// flag come straight from flops, so the consumer sees no combinational path.
// Ports:
//   clk, reset          - clock, asynchronous active-high reset
//   pushValid/pushData  - write side; accepted when not full or popping
//   popReady            - consumer ready; a pop happens on outValid & popReady
//   outValid/outData    - registered head of the queue
//   full                - registered full flag
// -----------------------------------------------------------------------------
module evt_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pushValid,
    input  logic [WIDTH-1:0] pushData,
    input  logic             popReady,
    output logic             outValid,
    output logic [WIDTH-1:0] outData,
    output logic             full
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rdPtrR;
    logic [AW-1:0]    wrPtrR;
    logic [AW:0]      countR;
    logic [AW-1:0]    rdNextS;
    logic [AW-1:0]    wrNextS;
    logic [AW:0]      countAfterPopS;
    logic [AW:0]      countNextS;
    logic [WIDTH-1:0] headNextS;
    logic             popS;
    logic             pushS;

    // Next pointers, occupancy and next head entry.
    always_comb begin
        popS           = outValid && popReady;
        pushS          = pushValid && (!full || popS);
        rdNextS        = rdPtrR + AW'(popS);
        wrNextS        = wrPtrR + AW'(pushS);
        countAfterPopS = countR - (AW+1)'(popS);
        countNextS     = countAfterPopS + (AW+1)'(pushS);
        // When the queue drains to empty in this cycle the pushed word becomes
        // the head directly; otherwise the head is an entry already in memory.
        if (countNextS == '0) begin
            headNextS = '0;
        end else if (pushS && (countAfterPopS == '0)) begin
            headNextS = pushData;
        end else begin
            headNextS = mem[rdNextS];
        end
    end

    // Storage array write port (contents need no reset).
    always_ff @(posedge clk) begin
        if (pushS) begin
            mem[wrPtrR] <= pushData;
        end
    end

    // Pointers, occupancy and registered head.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdPtrR   <= '0;
            wrPtrR   <= '0;
            countR   <= '0;
            outValid <= 1'b0;
            outData  <= '0;
            full     <= 1'b0;
        end else begin
            rdPtrR   <= rdNextS;
            wrPtrR   <= wrNextS;
            countR   <= countNextS;
            outValid <= (countNextS != '0);
            outData  <= headNextS;
            full     <= (countNextS == (AW+1)'(DEPTH));
        end
    end

endmodule

// File: rtl/collision_tracker.sv
// -----------------------------------------------------------------------------
// collision_tracker
// Detects per-pixel overlap of drawable objects, accumulates per-pair
// collisions over a frame, records the first collision coordinate and streams
// one event per newly colliding pair through a show-ahead FIFO.
// Ports:
//   clk, reset                 - clock, asynchronous active-high reset
//   drawingRequest[NUM_OBJ]    - per-object draw request for current pixel
//   pixelX, pixelY             - current pixel coordinate
//   startOfFrame               - one-cycle frame boundary pulse
//   clearOverflow              - clears the sticky overflow flag
//   frameCollision             - per-pair result of the last completed frame
//   firstHitX/Y, firstHitValid - first collision of the last completed frame
//   evtValid/evtReady          - event stream handshake
//   evtPair, evtFrame          - event payload (pair index, frame counter)
//   overflow                   - sticky: events were dropped at a frame edge
// -----------------------------------------------------------------------------
module collision_tracker
    import collision_pkg::*;
#(
    parameter int                           NUM_OBJ   = 8,
    parameter logic [NUM_OBJ*NUM_OBJ-1:0]   PAIR_MASK = '1,
    parameter int                           EVT_DEPTH = 8,
    localparam int                          NUM_PAIR  = NUM_OBJ * NUM_OBJ,
    localparam int                          PAIR_W    = pairIdxWidth(NUM_OBJ)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_OBJ-1:0]  drawingRequest,
    input  logic [10:0]         pixelX,
    input  logic [10:0]         pixelY,
    input  logic                startOfFrame,
    input  logic                clearOverflow,
    output logic [NUM_PAIR-1:0] frameCollision,
    output logic [10:0]         firstHitX,
    output logic [10:0]         firstHitY,
    output logic                firstHitValid,
    output logic                evtValid,
    input  logic                evtReady,
    output logic [PAIR_W-1:0]   evtPair,
    output logic [7:0]          evtFrame,
    output logic                overflow
);

    localparam logic [NUM_PAIR-1:0] PAIR_ONE = {{(NUM_PAIR-1){1'b0}}, 1'b1};

    trackStateT          stateR;
    trackStateT          stateNextS;
    logic [NUM_PAIR-1:0] hitS;
    logic [NUM_PAIR-1:0] stickyR;
    logic [NUM_PAIR-1:0] pendingR;
    logic [NUM_PAIR-1:0] stickyBaseS;
    logic [NUM_PAIR-1:0] liveHitS;
    logic [NUM_PAIR-1:0] newHitS;
    logic [NUM_PAIR-1:0] popMaskS;
    logic [NUM_PAIR-1:0] remainS;
    logic [NUM_PAIR-1:0] stickyNextS;
    logic [NUM_PAIR-1:0] pendingNextS;
    logic [7:0]          frameCntR;
    logic [10:0]         scanXR;
    logic [10:0]         scanYR;
    logic                scanValidR;
    logic [10:0]         scanXNextS;
    logic [10:0]         scanYNextS;
    logic                scanValidNextS;
    logic                scanBaseValidS;
    logic                captureS;
    logic                sofScanS;
    logic                popAnyS;
    logic [PAIR_W-1:0]   popIdxS;
    logic                canPushS;
    logic                pushS;
    logic                overflowSetS;
    logic                fifoFullS;
    evtT                 pushDataS;
    evtT                 headS;
    logic                unusedPairBits;

    // Raw per-pair hits; only the upper triangle (i<j) can ever be set.
    always_comb begin
        hitS = '0;
        for (int i = 0; i < NUM_OBJ; i++) begin
            for (int j = 0; j < NUM_OBJ; j++) begin
                if (i < j) begin
                    hitS[i*NUM_OBJ+j] = drawingRequest[i] & drawingRequest[j]
                                        & PAIR_MASK[i*NUM_OBJ+j];
                end else begin
                    hitS[i*NUM_OBJ+j] = 1'b0;
                end
            end
        end
    end

    // Pending/sticky/first-hit update and event push selection.
    always_comb begin
        // Lowest-index pending pair: scan downwards so the last match wins.
        popAnyS = |pendingR;
        popIdxS = '0;
        for (int k = NUM_PAIR - 1; k >= 0; k--) begin
            popIdxS = pendingR[k] ? PAIR_W'(k) : popIdxS;
        end

        // A full FIFO still accepts a push when it pops in the same cycle.
        canPushS = !fifoFullS || (evtValid && evtReady);
        pushS    = popAnyS && canPushS;
        popMaskS = pushS ? (PAIR_ONE << popIdxS) : '0;
        remainS  = pendingR & ~popMaskS;

        sofScanS = startOfFrame && (stateR == SCAN);
        liveHitS = (stateR == SCAN) ? hitS : '0;

        // At a frame edge the sticky set restarts, so a coincident hit counts
        // as new in the next frame; left-over pending events are discarded.
        stickyBaseS  = sofScanS ? '0 : stickyR;
        newHitS      = liveHitS & ~stickyBaseS;
        stickyNextS  = stickyBaseS | liveHitS;
        pendingNextS = (sofScanS ? '0 : remainS) | newHitS;
        overflowSetS = sofScanS && (|remainS);

        scanBaseValidS = sofScanS ? 1'b0 : scanValidR;
        captureS       = (|newHitS) && !scanBaseValidS;
        scanValidNextS = captureS ? 1'b1 : scanBaseValidS;
        scanXNextS     = captureS ? pixelX : (sofScanS ? 11'd0 : scanXR);
        scanYNextS     = captureS ? pixelY : (sofScanS ? 11'd0 : scanYR);

        pushDataS.pair  = MAX_PAIR_W'(popIdxS);
        pushDataS.frame = frameCntR;
    end

    // FSM next state: wait for the first frame edge, then scan forever.
    always_comb begin
        stateNextS = stateR;
        case (stateR)
            WAIT_SOF: stateNextS = startOfFrame ? SCAN : WAIT_SOF;
            SCAN:     stateNextS = SCAN;
            default:  stateNextS = WAIT_SOF;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateR <= WAIT_SOF;
        end else begin
            stateR <= stateNextS;
        end
    end

    // Scan state, frame results and overflow flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stickyR        <= '0;
            pendingR       <= '0;
            frameCntR      <= 8'd0;
            scanXR         <= 11'd0;
            scanYR         <= 11'd0;
            scanValidR     <= 1'b0;
            frameCollision <= '0;
            firstHitX      <= 11'd0;
            firstHitY      <= 11'd0;
            firstHitValid  <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            stickyR    <= stickyNextS;
            pendingR   <= pendingNextS;
            scanXR     <= scanXNextS;
            scanYR     <= scanYNextS;
            scanValidR <= scanValidNextS;
            if (sofScanS) begin
                frameCollision <= stickyR;
                firstHitX      <= scanXR;
                firstHitY      <= scanYR;
                firstHitValid  <= scanValidR;
                frameCntR      <= frameCntR + 8'd1;
            end
            // Setting wins over a coincident clear.
            if (overflowSetS) begin
                overflow <= 1'b1;
            end else if (clearOverflow) begin
                overflow <= 1'b0;
            end
        end
    end

    evt_fifo #(
        .WIDTH ($bits(evtT)),
        .DEPTH (EVT_DEPTH)
    ) u_evt_fifo (
        .clk       (clk),
        .reset     (reset),
        .pushValid (pushS),
        .pushData  (pushDataS),
        .popReady  (evtReady),
        .outValid  (evtValid),
        .outData   (headS),
        .full      (fifoFullS)
    );

    assign evtPair  = headS.pair[PAIR_W-1:0];
    assign evtFrame = headS.frame;

    // Pair bits above PAIR_W are always zero for small object counts.
    assign unusedPairBits = ^headS.pair;

endmodule

// File: tb/tb_collision_tracker.sv
// -----------------------------------------------------------------------------
// tb_collision_tracker
// Directed scenarios plus randomized traffic, checked cycle by cycle against a
// behavioural model built from per-pair bit arrays and an event queue.
// -----------------------------------------------------------------------------
module tb_collision_tracker;

    localparam int N     = 8;
    localparam int NP    = N * N;
    localparam int DEPTH = 8;
    localparam int PW    = 6;
    // Pair (5,6) -> bit 46 disabled.
    localparam logic [NP-1:0] MASK = 64'hFFFF_BFFF_FFFF_FFFF;

    logic          clk = 1'b0;
    logic          reset;
    logic [N-1:0]  drawingRequest;
    logic [10:0]   pixelX;
    logic [10:0]   pixelY;
    logic          startOfFrame;
    logic          clearOverflow;
    logic [NP-1:0] frameCollision;
    logic [10:0]   firstHitX;
    logic [10:0]   firstHitY;
    logic          firstHitValid;
    logic          evtValid;
    logic          evtReady;
    logic [PW-1:0] evtPair;
    logic [7:0]    evtFrame;
    logic          overflow;

    always #5 clk = ~clk;

    collision_tracker #(
        .NUM_OBJ   (N),
        .PAIR_MASK (MASK),
        .EVT_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .drawingRequest (drawingRequest),
        .pixelX         (pixelX),
        .pixelY         (pixelY),
        .startOfFrame   (startOfFrame),
        .clearOverflow  (clearOverflow),
        .frameCollision (frameCollision),
        .firstHitX      (firstHitX),
        .firstHitY      (firstHitY),
        .firstHitValid  (firstHitValid),
        .evtValid       (evtValid),
        .evtReady       (evtReady),
        .evtPair        (evtPair),
        .evtFrame       (evtFrame),
        .overflow       (overflow)
    );

    int nChecks = 0;
    int nFails  = 0;

    // Behavioural model state
    bit mScan;
    bit mSticky [NP];
    bit mPend   [NP];
    bit mFc     [NP];
    int mQp [$];
    int mQf [$];
    int mFrame;
    int mScanX, mScanY, mFhX, mFhY;
    bit mScanV, mFhV, mOvf;

    task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic modelReset();
        mScan = 1'b0;
        for (int p = 0; p < NP; p++) begin
            mSticky[p] = 1'b0; mPend[p] = 1'b0; mFc[p] = 1'b0;
        end
        mQp.delete(); mQf.delete();
        mFrame = 0; mScanX = 0; mScanY = 0; mScanV = 1'b0;
        mFhX = 0; mFhY = 0; mFhV = 1'b0; mOvf = 1'b0;
    endtask

    // One clock edge of the reference behaviour, using the inputs held this cycle.
    task automatic modelStep();
        int low;
        bit setOvf;
        if (mQp.size() > 0 && evtReady) begin
            void'(mQp.pop_front());
            void'(mQf.pop_front());
        end
        low = -1;
        for (int p = NP - 1; p >= 0; p--) if (mPend[p]) low = p;
        if (low >= 0 && mQp.size() < DEPTH) begin
            mQp.push_back(low);
            mQf.push_back(mFrame);
            mPend[low] = 1'b0;
        end
        setOvf = 1'b0;
        if (mScan && startOfFrame) begin
            for (int p = 0; p < NP; p++) begin
                mFc[p] = mSticky[p];
                if (mPend[p]) setOvf = 1'b1;
                mPend[p] = 1'b0;
                mSticky[p] = 1'b0;
            end
            mFhX = mScanX; mFhY = mScanY; mFhV = mScanV;
            mScanX = 0; mScanY = 0; mScanV = 1'b0;
            mFrame = (mFrame + 1) % 256;
        end
        if (setOvf) mOvf = 1'b1;
        else if (clearOverflow) mOvf = 1'b0;
        if (mScan) begin
            for (int i = 0; i < N; i++) begin
                for (int j = i + 1; j < N; j++) begin
                    if (drawingRequest[i] && drawingRequest[j] && MASK[i*N+j] && !mSticky[i*N+j]) begin
                        mSticky[i*N+j] = 1'b1;
                        mPend[i*N+j] = 1'b1;
                        if (!mScanV) begin
                            mScanX = pixelX; mScanY = pixelY; mScanV = 1'b1;
                        end
                    end
                end
            end
        end else if (startOfFrame) begin
            mScan = 1'b1;
        end
    endtask

    task automatic compareAll();
        logic [NP-1:0] fc;
        for (int p = 0; p < NP; p++) fc[p] = mFc[p];
        checkVal("evtValid", evtValid, 64'(mQp.size() != 0));
        if (mQp.size() != 0) begin
            checkVal("evtPair", evtPair, mQp[0]);
            checkVal("evtFrame", evtFrame, mQf[0]);
        end
        checkVal("frameCollision", frameCollision, fc);
        checkVal("firstHitX", firstHitX, mFhX);
        checkVal("firstHitY", firstHitY, mFhY);
        checkVal("firstHitValid", firstHitValid, mFhV);
        checkVal("overflow", overflow, mOvf);
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) modelReset();
        else modelStep();
        #1;
        compareAll();
        @(negedge clk);
    endtask

    task automatic cyc(input logic [N-1:0] dr, input logic sof);
        drawingRequest = dr;
        startOfFrame   = sof;
        tick();
        drawingRequest = '0;
        startOfFrame   = 1'b0;
    endtask

    initial begin
        int gap;
        reset = 1'b1; drawingRequest = '0; pixelX = 11'd0; pixelY = 11'd0;
        startOfFrame = 1'b0; clearOverflow = 1'b0; evtReady = 1'b1;
        modelReset();
        @(negedge clk);
        tick(); tick();
        checkVal("rst_frameCollision", frameCollision, 64'd0);
        checkVal("rst_evtValid", evtValid, 64'd0);
        reset = 1'b0;

        // Enter SCAN, frame 0; single overlap of objects 0 and 1.
        cyc('0, 1'b1);
        pixelX = 11'd100; pixelY = 11'd50;
        cyc(8'b0000_0011, 1'b0);
        checkVal("r34_notYet", evtValid, 64'd0);
        pixelX = 11'd7; pixelY = 11'd9;
        cyc('0, 1'b0);
        checkVal("r34_valid", evtValid, 64'd1);
        checkVal("r34_pair", evtPair, 64'd1);
        checkVal("r34_frame", evtFrame, 64'd0);
        cyc('0, 1'b0);
        cyc('0, 1'b1);
        checkVal("r34_fc", frameCollision, 64'h2);
        checkVal("r34_x", firstHitX, 64'd100);
        checkVal("r34_y", firstHitY, 64'd50);
        checkVal("r34_v", firstHitValid, 64'd1);

        // Objects 0,2,3 -> pairs 2, 3, 19 on consecutive cycles.
        cyc(8'b0000_1101, 1'b0);
        cyc('0, 1'b0); checkVal("r35_e0", evtPair, 64'd2);
        cyc('0, 1'b0); checkVal("r35_e1", evtPair, 64'd3);
        cyc('0, 1'b0); checkVal("r35_e2", evtPair, 64'd19);
        cyc('0, 1'b0); checkVal("r35_empty", evtValid, 64'd0);

        // Ten pairs with the consumer stalled, then drained before the edge.
        evtReady = 1'b0;
        cyc(8'b0001_1111, 1'b0);
        repeat (10) cyc('0, 1'b0);
        checkVal("r36_head", evtPair, 64'd1);
        evtReady = 1'b1;
        repeat (12) cyc('0, 1'b0);
        cyc('0, 1'b1);
        checkVal("r36_noOvf", overflow, 64'd0);
        // Same again but stalled across the frame edge.
        evtReady = 1'b0;
        cyc(8'b0001_1111, 1'b0);
        repeat (10) cyc('0, 1'b0);
        cyc('0, 1'b1);
        checkVal("r36_ovf", overflow, 64'd1);
        // Clear alone, then set coinciding with clear.
        clearOverflow = 1'b1; cyc('0, 1'b0); clearOverflow = 1'b0;
        checkVal("r36_cleared", overflow, 64'd0);
        cyc(8'b0001_1111, 1'b0);
        repeat (3) cyc('0, 1'b0);
        clearOverflow = 1'b1; cyc('0, 1'b1); clearOverflow = 1'b0;
        checkVal("r28_setWins", overflow, 64'd1);
        evtReady = 1'b1;
        repeat (12) cyc('0, 1'b0);
        clearOverflow = 1'b1; cyc('0, 1'b0); clearOverflow = 1'b0;
        cyc('0, 1'b1);

        // Masked pair (5,6) produces nothing.
        cyc(8'b0110_0000, 1'b0);
        repeat (3) cyc('0, 1'b0);
        checkVal("r37_noEvt", evtValid, 64'd0);
        cyc('0, 1'b1);
        checkVal("r37_fc", frameCollision, 64'd0);
        checkVal("r37_v", firstHitValid, 64'd0);

        // Run the frame counter up to 255, then hit together with the edge.
        for (int n = 0; n < 300 && mFrame != 255; n++) begin
            cyc('0, 1'b1);
            cyc('0, 1'b0);
        end
        pixelX = 11'd1234; pixelY = 11'd777;
        cyc(8'b0000_0011, 1'b1);
        cyc('0, 1'b0);
        checkVal("r38_valid", evtValid, 64'd1);
        checkVal("r38_wrapFrame", evtFrame, 64'd0);
        cyc('0, 1'b0);
        cyc('0, 1'b1);
        checkVal("r38_fc", frameCollision, 64'h2);
        checkVal("r38_x", firstHitX, 64'd1234);

        // Asynchronous reset with three events queued.
        evtReady = 1'b0;
        cyc(8'b0000_0111, 1'b0);
        repeat (4) cyc('0, 1'b0);
        checkVal("r39_queued", evtValid, 64'd1);
        #2;
        reset = 1'b1;
        #1;
        modelReset();
        checkVal("r39_asyncValid", evtValid, 64'd0);
        compareAll();
        @(negedge clk);
        tick();
        reset = 1'b0;
        evtReady = 1'b1;
        cyc('0, 1'b1);
        repeat (3) cyc('0, 1'b0);
        cyc('0, 1'b1);
        checkVal("r39_fc", frameCollision, 64'd0);
        checkVal("r39_v", firstHitValid, 64'd0);
        checkVal("r39_ovf", overflow, 64'd0);

        // Randomized traffic.
        gap = 20;
        for (int c = 0; c < 4000; c++) begin
            logic [N-1:0] dr;
            for (int b = 0; b < N; b++) dr[b] = ($urandom_range(0, 5) == 0);
            pixelX        = 11'($urandom);
            pixelY        = 11'($urandom);
            evtReady      = ($urandom_range(0, 3) != 0);
            clearOverflow = ($urandom_range(0, 30) == 0);
            gap--;
            if (gap == 0) gap = $urandom_range(5, 60);
            cyc(dr, gap == 1);
        end
        clearOverflow = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
